// File: rtl/qei_gen_pkg.sv
// qei_gen shared constants, A/B phase encoding and phase stepping.
// Direction encoding matches the qei receiver (1 = reverse).
package qei_gen_pkg;

  localparam int CLK_FREQ       = 50_000_000;
  localparam int PID_SPEED_FREQ = 1_000;
  localparam int QEI_RES        = 16;
  localparam int QEIGEN_MIN_GAP = 4;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_10 = 2'b10,
    AB_11 = 2'b11,
    AB_01 = 2'b01
  } ab_t;

  // forward: 00->10->11->01 (A leads B)
  function automatic ab_t ab_step(
    input ab_t  s,
    input logic dir
  );
    ab_t n;
    n = s;
    unique case (s)
      AB_00:   n = (dir == DIR_REV) ? AB_01 : AB_10;
      AB_10:   n = (dir == DIR_REV) ? AB_00 : AB_11;
      AB_11:   n = (dir == DIR_REV) ? AB_10 : AB_01;
      AB_01:   n = (dir == DIR_REV) ? AB_11 : AB_00;
      default: n = AB_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qei_gen_counter.sv
// Free-running modulo counter used as the update-period timer.
// overflow is a pure decode of the count register.
module qei_gen_counter #(
  parameter int modulus = 2,
  parameter int width   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic overflow
);

  localparam logic [width-1:0] LAST = width'(modulus - 1);

  logic [width-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + width'(1);
    end
  end

  assign overflow = (count == LAST);

endmodule

// File: rtl/qei_gen.sv
// Quadrature encoder generator: spreads a signed per-period edge count
// evenly over the update period as A/B Gray steps.
module qei_gen
  import qei_gen_pkg::*;
#(
  parameter int clk_freq = CLK_FREQ,
  parameter int upd_freq = PID_SPEED_FREQ,
  parameter int nbits    = QEI_RES,
  parameter int min_gap  = QEIGEN_MIN_GAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [nbits-1:0] speed_i,
  output logic                    A_o,
  output logic                    B_o,
  output logic                    dir_o,
  output logic                    sat_o,
  output logic                    tick_o,
  output logic signed [nbits-1:0] edge_cnt_o
);

  localparam int P     = clk_freq / upd_freq;
  localparam int M_MAX = P / min_gap;
  localparam int TW    = (P > 1) ? $clog2(P) : 1;
  localparam int AW    = $clog2(P) + 1;
  localparam int MW    = (M_MAX > 0) ? $clog2(M_MAX + 1) : 1;

  logic                    tick;
  logic [nbits:0]          ext;
  logic [nbits:0]          mag;
  logic                    sat;
  logic [MW-1:0]           m_new;
  logic [MW-1:0]           m_r;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           sum;
  logic                    step;
  logic signed [nbits-1:0] run_cnt;
  ab_t                     ab;
  ab_t                     ab_nx;

  qei_gen_counter #(
    .modulus (P),
    .width   (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .overflow (tick_o)
  );

  assign tick = tick_o && en && !clr;

  // one extra bit so |-2^(nbits-1)| is representable
  assign ext   = {speed_i[nbits-1], speed_i};
  assign mag   = ext[nbits] ? -ext : ext;
  assign sat   = mag > (nbits+1)'(M_MAX);
  assign m_new = sat ? MW'(M_MAX) : mag[MW-1:0];

  assign sum  = acc + AW'(m_r);
  assign step = en && !clr && !tick && (sum >= AW'(P));

  // acc is preloaded with m so the m-th crossing lands on the last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      m_r        <= '0;
      dir_o      <= 1'b0;
      sat_o      <= 1'b0;
      run_cnt    <= '0;
      edge_cnt_o <= '0;
    end else if (clr) begin
      acc        <= '0;
      m_r        <= '0;
      dir_o      <= 1'b0;
      sat_o      <= 1'b0;
      run_cnt    <= '0;
      edge_cnt_o <= '0;
    end else if (en) begin
      if (tick) begin
        acc        <= AW'(m_new);
        m_r        <= m_new;
        dir_o      <= speed_i[nbits-1];
        sat_o      <= sat;
        edge_cnt_o <= run_cnt;
        run_cnt    <= '0;
      end else if (step) begin
        acc     <= sum - AW'(P);
        run_cnt <= (dir_o == DIR_REV) ?
                   run_cnt - nbits'(1) :
                   run_cnt + nbits'(1);
      end else begin
        acc <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab <= AB_00;
    end else begin
      ab <= ab_nx;
    end
  end

  always_comb begin
    ab_nx = ab;
    if (step) begin
      ab_nx = ab_step(ab, dir_o);
    end
  end

  always_comb begin
    A_o = ab[1];
    B_o = ab[0];
  end

endmodule

// File: tb/tb_qei_gen.sv
// Directed bench for qei_gen with a per-period scoreboard and an
// independent quadrature decoder watching A/B.
module tb_qei_gen;

  localparam int P  = 100;
  localparam int MM = 25;

  typedef struct {
    int   cnt;
    int   m;
    logic sat;
    logic dir;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               en  = 1'b0;
  logic signed [15:0] speed_i = '0;
  logic               A_o, B_o, dir_o, sat_o, tick_o;
  logic signed [15:0] edge_cnt_o;

  int   vecs = 0;
  int   errs = 0;
  int   cycle = 0;
  int   qcnt = 0;
  int   bad = 0;
  int   last_edge = -1;
  int   pmin = 1 << 30;
  int   pmax = 0;
  bit   clean = 1'b0;
  logic [1:0] ab_prev = 2'b00;
  exp_t q[$];

  qei_gen #(
    .clk_freq (1000),
    .upd_freq (10),
    .nbits    (16),
    .min_gap  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (en),
    .speed_i    (speed_i),
    .A_o        (A_o),
    .B_o        (B_o),
    .dir_o      (dir_o),
    .sat_o      (sat_o),
    .tick_o     (tick_o),
    .edge_cnt_o (edge_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic exp_t mk_exp(input int s);
    exp_t e;
    int   mag;
    mag   = (s < 0) ? -s : s;
    e.sat = (mag > MM);
    e.m   = e.sat ? MM : mag;
    e.dir = (s < 0);
    e.cnt = e.dir ? -e.m : e.m;
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_ge(input string tag, input int obs, input int lo);
    vecs++;
    assert (obs >= lo) else begin
      errs++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, lo);
    end
  endtask

  task automatic check_le(input string tag, input int obs, input int hi);
    vecs++;
    assert (obs <= hi) else begin
      errs++;
      $error("FAIL %s: observed %0d expected <= %0d", tag, obs, hi);
    end
  endtask

  // advance to the next falling edge and decode any A/B movement
  task automatic cyc();
    logic [1:0] ab;
    int g;
    @(negedge clk);
    cycle++;
    ab = {A_o, B_o};
    if (ab != ab_prev) begin
      if (ab == fwd(ab_prev)) qcnt++;
      else if (fwd(ab) == ab_prev) qcnt--;
      else bad++;
      if (last_edge >= 0) begin
        g = cycle - last_edge;
        if (g < pmin) pmin = g;
        if (g > pmax) pmax = g;
      end
      last_edge = cycle;
      ab_prev = ab;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_o && n < 3 * P);
    check("tick_seen", int'(tick_o), 1);
  endtask

  task automatic restart_model();
    q.delete();
    q.push_back(mk_exp(0));
    qcnt = 0;
    last_edge = -1;
    pmin = 1 << 30;
    pmax = 0;
    clean = 1'b0;
  endtask

  // called on a tick cycle: closes the running period, opens the next
  task automatic boundary(input int s);
    exp_t e;
    int   pq, pmn, pmx;
    bit   was_clean;
    e = '{cnt: 0, m: 0, sat: 1'b0, dir: 1'b0};
    if (q.size() > 0) e = q.pop_front();
    else check("scoreboard_empty", q.size(), 1);
    pq = qcnt;
    pmn = pmin;
    pmx = pmax;
    was_clean = clean;
    qcnt = 0;
    pmin = 1 << 30;
    pmax = 0;
    last_edge = -1;
    clean = 1'b1;
    speed_i = 16'(s);
    q.push_back(mk_exp(s));
    cyc();
    check("edge_cnt", int'(edge_cnt_o), e.cnt);
    check("decoded", pq, e.cnt);
    check("sat", int'(sat_o), int'(q[0].sat));
    check("dir", int'(dir_o), int'(q[0].dir));
    check("gray_step", bad, 0);
    if (was_clean && e.m >= 2) begin
      check_ge("gap_min", pmn, P / e.m);
      check_le("gap_max", pmx, (P + e.m - 1) / e.m);
      check_ge("gap_floor", pmn, 4);
    end
  endtask

  initial begin
    logic [1:0] ab0;
    int q0;

    #1 rst = 1'b0;
    cyc();
    cyc();
    check("rst_A", int'(A_o), 0);
    check("rst_B", int'(B_o), 0);
    check("rst_dir", int'(dir_o), 0);
    check("rst_sat", int'(sat_o), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_cnt", int'(edge_cnt_o), 0);

    rst = 1'b1;
    en = 1'b1;
    restart_model();
    repeat (P - 2) cyc();
    check("first_tick_early", int'(tick_o), 0);
    cyc();
    check("first_tick", int'(tick_o), 1);

    boundary(10);
    wait_tick();
    boundary(10);
    wait_tick();
    boundary(-3);
    wait_tick();
    boundary(100);
    wait_tick();
    boundary(-32768);
    wait_tick();
    boundary(10);

    // command change mid-period is deferred to the next tick
    repeat (50) cyc();
    speed_i = 16'sd20;
    wait_tick();
    boundary(20);
    wait_tick();
    boundary(0);
    ab0 = {A_o, B_o};
    wait_tick();
    check("static_ab", int'({A_o, B_o}), int'(ab0));
    boundary(10);

    // enable low freezes everything
    repeat (20) cyc();
    en = 1'b0;
    ab0 = {A_o, B_o};
    q0 = qcnt;
    repeat (30) cyc();
    check("en_hold_ab", int'({A_o, B_o}), int'(ab0));
    check("en_hold_cnt", qcnt, q0);
    clean = 1'b0;
    en = 1'b1;
    wait_tick();
    boundary(-5);

    // clear mid-period: phase kept, counts and flags zeroed
    repeat (40) cyc();
    ab0 = {A_o, B_o};
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_ab", int'({A_o, B_o}), int'(ab0));
    check("clr_cnt", int'(edge_cnt_o), 0);
    check("clr_dir", int'(dir_o), 0);
    check("clr_sat", int'(sat_o), 0);
    restart_model();
    repeat (P - 2) cyc();
    check("clr_tick_early", int'(tick_o), 0);
    cyc();
    check("clr_tick", int'(tick_o), 1);
    boundary(7);

    for (int i = 1; i <= MM; i++) begin
      wait_tick();
      boundary(i);
      wait_tick();
      boundary(-i);
    end
    wait_tick();
    boundary(-10);

    // asynchronous reset in the middle of a period
    repeat (36) cyc();
    #2 rst = 1'b0;
    #1;
    check("arst_A", int'(A_o), 0);
    check("arst_B", int'(B_o), 0);
    check("arst_dir", int'(dir_o), 0);
    check("arst_sat", int'(sat_o), 0);
    check("arst_tick", int'(tick_o), 0);
    check("arst_cnt", int'(edge_cnt_o), 0);
    ab_prev = 2'b00;
    cyc();
    cyc();
    rst = 1'b1;
    restart_model();
    repeat (P - 2) cyc();
    check("rel_tick_early", int'(tick_o), 0);
    cyc();
    check("rel_tick", int'(tick_o), 1);
    boundary(4);
    wait_tick();
    boundary(0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
